// File: rtl/dtree_seq_pkg.sv
// Shared types and the default node table for the sequential decision-tree walker.
// Table generators rewrite only the DTREE_NODES block below.
package dtree_seq_pkg;

  localparam int FEAT_IDX_W = 3;
  localparam int SHIFT_W    = 3;
  localparam int THR_W      = 8;
  localparam int PTR_W      = 3;
  localparam int CLS_W      = 5;
  localparam int TBL_N      = 7;

  typedef struct packed {
    logic                  is_leaf;
    logic [FEAT_IDX_W-1:0] feat_idx;
    logic [SHIFT_W-1:0]    shift;
    logic [THR_W-1:0]      thr;
    logic [PTR_W-1:0]      left;
    logic [PTR_W-1:0]      right;
    logic [CLS_W-1:0]      cls;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic node_t mk_split(input int f, input int s, input int t,
                                     input int l, input int r);
    node_t n;
    n          = '0;
    n.feat_idx = FEAT_IDX_W'(f);
    n.shift    = SHIFT_W'(s);
    n.thr      = THR_W'(t);
    n.left     = PTR_W'(l);
    n.right    = PTR_W'(r);
    return n;
  endfunction

  function automatic node_t mk_leaf(input int c);
    node_t n;
    n         = '0;
    n.is_leaf = 1'b1;
    n.cls     = CLS_W'(c);
    return n;
  endfunction

  localparam node_t DTREE_NODES [TBL_N] = '{
    mk_split(6, 6, 0, 1, 2),
    mk_leaf(1),
    mk_split(1, 6, 2, 3, 4),
    mk_leaf(2),
    mk_split(6, 4, 10, 5, 6),
    mk_leaf(3),
    mk_leaf(4)
  };

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node lookup into the packaged table; addresses beyond the table
// return an all-zero non-leaf so a stray pointer is bounded by the depth limit.
module dtree_node_rom
  import dtree_seq_pkg::*;
#(
  parameter int N_NODES = 7,
  parameter int NODE_AW = $clog2(N_NODES)
) (
  input  logic [NODE_AW-1:0] addr,
  output node_t              node
);

  always_comb begin
    node = '0;
    for (int i = 0; i < TBL_N; i++) begin
      if (i < N_NODES && int'(addr) == i) begin
        node = DTREE_NODES[i];
      end
    end
  end

endmodule

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree evaluator: one node per clock through a single shared
// comparator, aborting with out_err once MAX_DEPTH nodes have been visited.
module dtree_seq_walker
  import dtree_seq_pkg::*;
#(
  parameter int N_FEAT    = 7,
  parameter int FEAT_W    = 8,
  parameter int CLASS_W   = 5,
  parameter int N_NODES   = 7,
  parameter int MAX_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] features,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err
);

  localparam int NODE_AW = $clog2(N_NODES);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  state_t                   state;
  logic [NODE_AW-1:0]       node_ptr;
  logic [DEPTH_W-1:0]       depth;
  logic [N_FEAT*FEAT_W-1:0] feat_reg;

  node_t                    node;
  logic [FEAT_W-1:0]        feat_sel;
  logic [FEAT_W-1:0]        feat_shifted;
  logic                     go_left;
  logic [NODE_AW-1:0]       child;
  logic                     depth_hit;

  dtree_node_rom #(
    .N_NODES (N_NODES),
    .NODE_AW (NODE_AW)
  ) u_rom (
    .addr (node_ptr),
    .node (node)
  );

  // Out-of-range feature index reads as zero.
  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (int'(node.feat_idx) == i) begin
        feat_sel = feat_reg[i*FEAT_W +: FEAT_W];
      end
    end
  end

  always_comb begin
    feat_shifted = feat_sel >> node.shift;
    go_left      = (feat_shifted <= FEAT_W'(node.thr));
    child        = go_left ? NODE_AW'(node.left) : NODE_AW'(node.right);
    depth_hit    = ((int'(depth) + 1) == MAX_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      node_ptr  <= '0;
      depth     <= '0;
      feat_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            feat_reg <= features;
            node_ptr <= '0;
            depth    <= '0;
            in_ready <= 1'b0;
            state    <= ST_WALK;
          end
        end
        ST_WALK: begin
          depth <= depth + DEPTH_W'(1);
          if (node.is_leaf) begin
            out_class <= CLASS_W'(node.cls);
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (depth_hit) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            node_ptr <= child;
          end
        end
        ST_DONE: begin
          // Input acceptance reopens only after the result has been taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dtree_seq_walker.md
# dtree_seq_walker

Sequential decision-tree evaluator that walks a stored node table one node per clock using a single shared comparator, instead of a fully unrolled comparator tree. It sits between the feature-capture front end (valid/ready producer of one feature vector) and the class consumer (valid/ready sink). It targets area-constrained printed classifiers where latency is cheap and comparators are expensive.

## Interface
Parameters:
- N_FEAT, 7: number of input features.
- FEAT_W, 8: width of each feature.
- CLASS_W, 5: width of class label.
- N_NODES, 7: node table entries; NODE_AW = $clog2(N_NODES).
- MAX_DEPTH, 8: max nodes visited per inference before error abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  walker idle, can accept.
- features  in  N_FEAT*FEAT_W  feature i at features[i*FEAT_W +: FEAT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_class  out  CLASS_W  predicted class.
- out_err  out  1  depth limit hit; out_class = 0.

## Operation
- Node record (from ROM): is_leaf, feat_idx, shift (0..FEAT_W-1), thr (FEAT_W bits, zero-extended), left, right (NODE_AW), cls (CLASS_W).
- Compare: (feat_reg[feat_idx] >> shift) <= thr, unsigned. True → left, false → right.
- FSM states IDLE, WALK, DONE. Reset → IDLE; all outputs 0 except in_ready = 1; node_ptr = 0, depth = 0, feature register = 0.
- IDLE: in_ready = 1. On in_valid & in_ready: latch features, node_ptr ← 0, depth ← 0, go WALK.
- WALK: in_ready = 0; each cycle read node[node_ptr] combinationally and increment depth.
  - Leaf: out_class ← cls, out_err ← 0, out_valid ← 1, go DONE.
  - Non-leaf, depth+1 == MAX_DEPTH: out_class ← 0, out_err ← 1, out_valid ← 1, go DONE.
  - Otherwise: node_ptr ← chosen child.
- DONE: hold out_valid/out_class/out_err stable until out_ready. On out_ready: out_valid ← 0, go IDLE. in_ready stays 0 throughout DONE; no overlap of input acceptance and output handshake.
- feat_idx ≥ N_FEAT selects value 0. Child pointer ≥ N_NODES is caught by MAX_DEPTH, not checked separately.
- Features are sampled only at acceptance; input changes during WALK/DONE are ignored.

## Timing
- Acceptance edge E0. A path visiting K nodes (leaf included) raises out_valid at edge E0+K. Leaf at root → K = 1.
- Depth abort raises out_valid at edge E0+MAX_DEPTH.
- Result handshake at edge Ed: out_valid = 0 and in_ready = 1 after Ed. Next accept at Ed+1 at the earliest.
- Throughput: one inference per K+2 cycles with out_ready held high.
- rst asserted at any point, including mid-WALK or while out_valid is held: immediate return to reset values. The in-flight result is discarded.

## Structure
- Package dtree_seq_pkg holds: the node_t packed struct, the state enum, and the default node table constant DTREE_NODES:
  - n0: f6, s6, t0, L1, R2
  - n1: leaf cls 1
  - n2: f1, s6, t2, L3, R4
  - n3: leaf cls 2
  - n4: f6, s4, t10, L5, R6
  - n5: leaf cls 3
  - n6: leaf cls 4
- Sub-module dtree_node_rom: combinational lookup of node_t from address, indexing DTREE_NODES. Table generators regenerate only the package.

## Test plan
- X6=0x20: root true → n1 → out_class=1, out_err=0, out_valid at E0+2.
- X6=0xFF, X1=0x40: n0→n2→n3 → out_class=2, out_valid at E0+3.
- X6=0xA0, X1=0xC0 → n5, class 3; X6=0xB0, X1=0xC0 → n6, class 4; both at E0+4.
- MAX_DEPTH=2 override, X6=0xFF, X1=0x40 → out_err=1, out_class=0 at E0+2.
- out_ready held low 10 cycles after result: out_valid/out_class stable, in_ready=0, new in_valid ignored. Release → in_ready=1 next cycle. Back-to-back vectors give correct classes in order.
- rst pulsed at E0+1 mid-WALK → all outputs 0, in_ready=1. A following vector X6=0x20 returns class 1 normally.
